// File: rtl/steer_en_hyst.sv
// steer_en_hyst: rider steering-enable controller with weight hysteresis,
// balance-wait timer, and registered en_steer / rider_off outputs.
// Optional build macro STEER_DWELL_EN: step-off must persist for DWELL_CYC
// consecutive STEER_EN cycles before leaving STEER_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no rider, or rider below exit weight
// WAIT     | rider on board, timing a continuous balanced interval
// STEER_EN | steering enabled
// ILLEGAL  | unused encoding, falls back to IDLE; outputs forced to 0

module steer_en_hyst #(
    parameter int LD_W       = 12,
    parameter int MIN_WEIGHT = 'h200,
    parameter int HYST       = 'h20,
    parameter int TMR_W      = 26,
    parameter int FAST_SIM   = 0,
    parameter int DWELL_CYC  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [LD_W-1:0] lft_ld,
    input  logic [LD_W-1:0] rght_ld,
    output logic [LD_W:0]   ld_cell_diff,
    output logic            en_steer,
    output logic            rider_off,
    output logic [1:0]      state_o
);

    localparam int SW    = LD_W + 1;
    localparam int PW    = LD_W + 5;
    localparam int TMR_N = (FAST_SIM != 0) ? 15 : TMR_W;

    localparam logic signed [LD_W:0] ENTER_TH = SW'(MIN_WEIGHT + HYST);
    localparam logic signed [LD_W:0] EXIT_TH  = SW'(MIN_WEIGHT - HYST);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        STEER_EN = 2'd2,
        ILLEGAL  = 2'd3
    } state_t;

    state_t state, nxt;

    logic signed [LD_W:0] lft_x, rght_x, sum, diff, abs_diff, sum_q4, sum_s4;
    logic signed [PW-1:0] sum_s4_x, sum_15_16, abs_diff_x;
    logic sum_gt_min, sum_lt_min, diff_gt_fourth, diff_gt_15_16;
    logic step_off;

    logic [TMR_N-1:0] tmr;
    logic tmr_full, tmr_clr, tmr_inc, rider_off_nxt;

    // One extra bit of headroom keeps both sum and difference overflow-free.
    assign lft_x      = {lft_ld[LD_W-1], lft_ld};
    assign rght_x     = {rght_ld[LD_W-1], rght_ld};
    assign sum        = lft_x + rght_x;
    assign diff       = lft_x - rght_x;
    assign abs_diff   = diff[LD_W] ? -diff : diff;
    assign sum_q4     = sum >>> 2;
    assign sum_s4     = sum >>> 4;
    assign sum_s4_x   = {{4{sum_s4[LD_W]}}, sum_s4};
    assign sum_15_16  = sum_s4_x * 5'sd15;
    assign abs_diff_x = {4'b0000, abs_diff};

    assign ld_cell_diff   = diff;
    assign sum_gt_min     = (sum >= ENTER_TH);
    assign sum_lt_min     = (sum < EXIT_TH);
    assign diff_gt_fourth = (abs_diff > sum_q4);
    assign diff_gt_15_16  = (abs_diff_x > sum_15_16);
    assign tmr_full       = &tmr;

`ifdef STEER_DWELL_EN
    logic [7:0] dwell_cnt;

    // Exit fires on the cycle the consecutive count would reach DWELL_CYC.
    assign step_off = diff_gt_15_16 && (dwell_cnt == 8'(DWELL_CYC - 1));

    // Count consecutive heavy-imbalance cycles while steering stays enabled.
    always_ff @(posedge clk) begin
        if (rst)
            dwell_cnt <= 8'd0;
        else if (state == STEER_EN && diff_gt_15_16 && nxt == STEER_EN)
            dwell_cnt <= dwell_cnt + 8'd1;
        else
            dwell_cnt <= 8'd0;
    end
`else
    logic dwell_unused;

    assign dwell_unused = |8'(DWELL_CYC);
    assign step_off     = diff_gt_15_16;
`endif

    // Next-state decode; in-band sums hold the current state.
    always_comb begin
        nxt           = state;
        tmr_clr       = 1'b0;
        tmr_inc       = 1'b0;
        rider_off_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (sum_gt_min) begin
                    nxt     = WAIT;
                    tmr_clr = 1'b1;
                end
            end
            WAIT: begin
                if (sum_lt_min) begin
                    nxt = IDLE;
                end else if (diff_gt_fourth) begin
                    tmr_clr = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                    if (tmr_full)
                        nxt = STEER_EN;
                end
            end
            STEER_EN: begin
                if (sum_lt_min) begin
                    nxt           = IDLE;
                    rider_off_nxt = 1'b1;
                end else if (step_off) begin
                    nxt     = WAIT;
                    tmr_clr = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Balance-wait timer: cleared on WAIT entry or imbalance, counts in WAIT.
    always_ff @(posedge clk) begin
        if (rst)
            tmr <= '0;
        else if (tmr_clr)
            tmr <= '0;
        else if (tmr_inc)
            tmr <= tmr + TMR_N'(1);
    end

    // State register with outputs registered from next-state so they align.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            en_steer  <= 1'b0;
            rider_off <= 1'b0;
        end else begin
            state     <= nxt;
            en_steer  <= (nxt == STEER_EN);
            rider_off <= rider_off_nxt;
        end
    end

    assign state_o = (state == ILLEGAL) ? 2'd0 : state;

endmodule

// File: tb/tb_steer_en_hyst.sv
// Directed bench for steer_en_hyst (FAST_SIM=1, default widths/thresholds).
// Also handles builds with STEER_DWELL_EN defined.

module tb_steer_en_hyst;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] lft_ld = 12'h000;
    logic [11:0] rght_ld = 12'h000;
    logic [12:0] ld_cell_diff;
    logic        en_steer, rider_off;
    logic [1:0]  state_o;

    int n_cmp = 0;
    int n_err = 0;

    steer_en_hyst #(.FAST_SIM(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .lft_ld       (lft_ld),
        .rght_ld      (rght_ld),
        .ld_cell_diff (ld_cell_diff),
        .en_steer     (en_steer),
        .rider_off    (rider_off),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] lft;
        logic [11:0] rght;
        logic [12:0] diff;
        logic [1:0]  st;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [11:0] l, input logic [11:0] r);
        lft_ld  = l;
        rght_ld = r;
    endtask

    task automatic wait_en(input string name);
        int n;
        n = 0;
        while (en_steer !== 1'b1 && n < 40000) begin
            tick();
            n++;
        end
        chk(name, n, 32768);
        chk({name, "_state"}, {30'd0, state_o}, 2);
        chk({name, "_roff"}, {31'd0, rider_off}, 0);
    endtask

    initial begin
        // lft, rght, ld_cell_diff, state one edge after leaving reset
        vecs[0] = '{12'h110, 12'h110, 13'h0000, 2'd1};
        vecs[1] = '{12'h108, 12'h108, 13'h0000, 2'd0};
        vecs[2] = '{12'h110, 12'h10F, 13'h0001, 2'd0};
        vecs[3] = '{12'h7FF, 12'h7FF, 13'h0000, 2'd1};
        vecs[4] = '{12'h7FF, 12'h800, 13'h0FFF, 2'd0};
        vecs[5] = '{12'h800, 12'h7FF, 13'h1001, 2'd0};
        vecs[6] = '{12'h300, 12'hF00, 13'h0400, 2'd0};
        vecs[7] = '{12'h220, 12'h000, 13'h0220, 2'd1};
        vecs[8] = '{12'h000, 12'h000, 13'h0000, 2'd0};
        vecs[9] = '{12'hFFF, 12'h001, 13'h1FFE, 2'd0};

        // Reset held three cycles with a heavy rider present.
        rst = 1'b1;
        drive(12'h150, 12'h150);
        repeat (3) tick();
        chk("rst_en", {31'd0, en_steer}, 0);
        chk("rst_roff", {31'd0, rider_off}, 0);
        chk("rst_state", {30'd0, state_o}, 0);
        rst = 1'b0;
        tick();
        chk("rst_release_state", {30'd0, state_o}, 1);

        // Combinational difference and IDLE entry threshold table.
        for (int i = 0; i < 10; i++) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            drive(vecs[i].lft, vecs[i].rght);
            #1;
            chk($sformatf("vec%0d_diff", i), {19'd0, ld_cell_diff}, {19'd0, vecs[i].diff});
            tick();
            chk($sformatf("vec%0d_state", i), {30'd0, state_o}, {30'd0, vecs[i].st});
        end

        // Enable: balanced rider, en_steer rises 32768 edges after WAIT entry.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(12'h110, 12'h110);
        tick();
        chk("enable_wait", {30'd0, state_o}, 1);
        wait_en("enable_latency");

        // Sum 0x1E0 sits inside the band: steering stays enabled.
        drive(12'h0F0, 12'h0F0);
        repeat (3) tick();
        chk("hyst_hold_state", {30'd0, state_o}, 2);
        chk("hyst_hold_en", {31'd0, en_steer}, 1);

        // Step-off: heavy imbalance with enough weight to stay on board.
`ifdef STEER_DWELL_EN
        drive(12'h220, 12'h000);
        repeat (7) tick();
        chk("dwell7_state", {30'd0, state_o}, 2);
        drive(12'h110, 12'h110);
        tick();
        drive(12'h220, 12'h000);
        repeat (7) tick();
        chk("dwell_pre_state", {30'd0, state_o}, 2);
        tick();
`else
        drive(12'h220, 12'h000);
        tick();
`endif
        chk("stepoff_state", {30'd0, state_o}, 1);
        chk("stepoff_en", {31'd0, en_steer}, 0);
        chk("stepoff_roff", {31'd0, rider_off}, 0);

        // Imbalance at count 1000 restarts the full wait interval.
        drive(12'h110, 12'h110);
        repeat (1000) tick();
        chk("imb_pre_state", {30'd0, state_o}, 1);
        drive(12'h1A0, 12'h080);
        tick();
        chk("imb_state", {30'd0, state_o}, 1);
        drive(12'h110, 12'h110);
        wait_en("imb_restart_latency");

        // Sum 0x1DF drops below exit threshold: one-cycle rider_off.
        drive(12'h0F0, 12'h0EF);
        tick();
        chk("exit_state", {30'd0, state_o}, 0);
        chk("exit_roff", {31'd0, rider_off}, 1);
        chk("exit_en", {31'd0, en_steer}, 0);
        tick();
        chk("exit_roff_pulse", {31'd0, rider_off}, 0);

        // From IDLE, in-band sums do not enter WAIT.
        drive(12'h108, 12'h108);
        repeat (3) tick();
        chk("idle_hold_210", {30'd0, state_o}, 0);
        drive(12'h0F0, 12'h0F0);
        repeat (2) tick();
        chk("idle_hold_1e0", {30'd0, state_o}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
